// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-port bus arbiter: bus modes, FSM encoding and the
// round-robin pick helper.
package bus_arbiter_pkg;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Returns the port to grant; on a tie the port that did not win last time goes.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
    if (req0 && req1) return ~last_grant;
    return req1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester and BUS-side signal bundle of the arbiter; slave = arbiter, master = environment.
interface bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          req0;
  logic          req1;
  logic          mode0;
  logic          mode1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          done0;
  logic          done1;
  logic          err0;
  logic          err1;
  logic [DW-1:0] rdata;
  logic          busy;

  logic          BUS_mode;
  logic [AW-1:0] BUS_addr;
  logic [DW-1:0] BUS_wdata;
  logic          BUS_start_transaction;
  logic [DW-1:0] BUS_rdata;
  logic          BUS_rdata_valid;
  logic          BUS_write_done;

  modport slave (
    input  req0, req1, mode0, mode1, addr0, addr1, wdata0, wdata1,
    output done0, done1, err0, err1, rdata, busy,
    output BUS_mode, BUS_addr, BUS_wdata, BUS_start_transaction,
    input  BUS_rdata, BUS_rdata_valid, BUS_write_done
  );

  modport master (
    output req0, req1, mode0, mode1, addr0, addr1, wdata0, wdata1,
    input  done0, done1, err0, err1, rdata, busy,
    input  BUS_mode, BUS_addr, BUS_wdata, BUS_start_transaction,
    output BUS_rdata, BUS_rdata_valid, BUS_write_done
  );

endinterface

// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter for the shared memory/peripheral BUS: grants one requester,
// issues a single BUS transaction, and returns a registered done/err/rdata to the winner.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        r_state, w_state;
  logic          r_last_grant, w_last_grant;
  logic          r_gnt, w_gnt;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_mode, w_mode;
  logic [AW-1:0] r_addr, w_addr;
  logic [DW-1:0] r_wdata, w_wdata;
  logic [DW-1:0] r_rdata, w_rdata;
  logic          r_start, w_start;
  logic          r_done0, w_done0;
  logic          r_done1, w_done1;
  logic          r_err0, w_err0;
  logic          r_err1, w_err1;
  logic          r_busy, w_busy;
  logic          w_sel;
  logic          w_fin;
  logic          w_to;

  always_comb begin
    w_state      = r_state;
    w_last_grant = r_last_grant;
    w_gnt        = r_gnt;
    w_cnt        = r_cnt;
    w_mode       = r_mode;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_rdata      = r_rdata;
    w_start      = 1'b0;
    w_done0      = 1'b0;
    w_done1      = 1'b0;
    w_err0       = 1'b0;
    w_err1       = 1'b0;
    w_sel        = 1'b0;
    w_fin        = 1'b0;
    w_to         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_sel        = rr_pick(bus.req0, bus.req1, r_last_grant);
          w_gnt        = w_sel;
          w_last_grant = w_sel;
          w_mode       = w_sel ? bus.mode1  : bus.mode0;
          w_addr       = w_sel ? bus.addr1  : bus.addr0;
          w_wdata      = w_sel ? bus.wdata1 : bus.wdata0;
          w_start      = 1'b1;
          w_state      = ST_START;
        end
      end
      ST_START: begin
        w_cnt   = '0;
        w_state = ST_WAIT;
      end
      ST_WAIT: begin
        // Completions of the wrong type fall through to the counter branch.
        if (r_mode == BUS_READ && bus.BUS_rdata_valid) begin
          w_rdata = bus.BUS_rdata;
          w_fin   = 1'b1;
        end else if (r_mode == BUS_WRITE && bus.BUS_write_done) begin
          w_fin = 1'b1;
        end else if (TIMEOUT != 0 && r_cnt == TO_LAST) begin
          w_fin = 1'b1;
          w_to  = 1'b1;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
        if (w_fin) begin
          w_state = ST_DONE;
          w_done0 = ~r_gnt;
          w_done1 = r_gnt;
          w_err0  = ~r_gnt & w_to;
          w_err1  = r_gnt & w_to;
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_cnt        <= '0;
      r_mode       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_start      <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_last_grant <= w_last_grant;
      r_gnt        <= w_gnt;
      r_cnt        <= w_cnt;
      r_mode       <= w_mode;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_rdata      <= w_rdata;
      r_start      <= w_start;
      r_done0      <= w_done0;
      r_done1      <= w_done1;
      r_err0       <= w_err0;
      r_err1       <= w_err1;
      r_busy       <= w_busy;
    end
  end

  assign bus.done0                 = r_done0;
  assign bus.done1                 = r_done1;
  assign bus.err0                  = r_err0;
  assign bus.err1                  = r_err1;
  assign bus.rdata                 = r_rdata;
  assign bus.busy                  = r_busy;
  assign bus.BUS_mode              = r_mode;
  assign bus.BUS_addr              = r_addr;
  assign bus.BUS_wdata             = r_wdata;
  assign bus.BUS_start_transaction = r_start;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: read, write, round-robin contention, wrong completion,
// timeout and asynchronous reset mid-transaction.
module tb_bus_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   n_start;
  int   n_done;
  int   snap;

  bus_arbiter_if #(.AW(32), .DW(32)) bus ();

  bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.BUS_start_transaction) n_start++;
    if (bus.done0 || bus.done1) n_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; n_start = 0; n_done = 0;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.mode0 = 1'b0; bus.mode1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    bus.BUS_rdata = '0; bus.BUS_rdata_valid = 1'b0; bus.BUS_write_done = 1'b0;
    step(3);

    chk("rst_busy",  bus.busy, 0);
    chk("rst_start", bus.BUS_start_transaction, 0);
    chk("rst_done",  {bus.done0, bus.done1, bus.err0, bus.err1}, 0);
    chk("rst_bus",   {bus.BUS_mode, bus.BUS_addr, bus.BUS_wdata}, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    step(1);

    // single read on port 0, data returns two cycles after the start pulse
    snap = n_start;
    bus.req0 = 1'b1; bus.mode0 = 1'b0; bus.addr0 = 32'h100;
    step(1);
    chk("rd_start", bus.BUS_start_transaction, 1);
    chk("rd_addr",  bus.BUS_addr, 32'h100);
    chk("rd_busy",  bus.busy, 1);
    step(1);
    chk("rd_start_off", bus.BUS_start_transaction, 0);
    step(1);
    bus.BUS_rdata = 32'hDEADBEEF; bus.BUS_rdata_valid = 1'b1;
    step(1);
    bus.BUS_rdata_valid = 1'b0; bus.BUS_rdata = '0;
    chk("rd_done",  {bus.done0, bus.done1}, 2'b10);
    chk("rd_rdata", bus.rdata, 32'hDEADBEEF);
    chk("rd_err",   bus.err0, 0);
    bus.req0 = 1'b0;
    step(1);
    chk("rd_done_pulse", bus.done0, 0);
    chk("rd_idle",  bus.busy, 0);
    chk("rd_nstart", n_start - snap, 1);

    // write on port 1, write_done one cycle into WAIT
    bus.req1 = 1'b1; bus.mode1 = 1'b1; bus.addr1 = 32'h40; bus.wdata1 = 32'h55AA;
    step(1);
    chk("wr_mode",  bus.BUS_mode, 1);
    chk("wr_addr",  bus.BUS_addr, 32'h40);
    chk("wr_wdata", bus.BUS_wdata, 32'h55AA);
    step(1);
    bus.BUS_write_done = 1'b1;
    step(1);
    bus.BUS_write_done = 1'b0;
    chk("wr_done",  {bus.done0, bus.done1}, 2'b01);
    chk("wr_rdata_hold", bus.rdata, 32'hDEADBEEF);
    bus.req1 = 1'b0;
    step(1);
    chk("wr_hold_addr", bus.BUS_addr, 32'h40);

    // read on port 0 with a stray write_done in WAIT
    bus.req0 = 1'b1; bus.mode0 = 1'b0; bus.addr0 = 32'h200;
    step(2);
    bus.BUS_write_done = 1'b1;
    step(1);
    bus.BUS_write_done = 1'b0;
    chk("wc_ignored", {bus.done0, bus.done1, bus.busy}, 3'b001);
    bus.BUS_rdata = 32'h12345678; bus.BUS_rdata_valid = 1'b1;
    step(1);
    bus.BUS_rdata_valid = 1'b0;
    chk("wc_done",  {bus.done0, bus.err0}, 2'b10);
    chk("wc_rdata", bus.rdata, 32'h12345678);
    bus.req0 = 1'b0;
    step(1);

    // tie with port 0 served last: port 1 wins, port 0 follows
    bus.req0 = 1'b1; bus.mode0 = 1'b0; bus.addr0 = 32'h300;
    bus.req1 = 1'b1; bus.mode1 = 1'b1; bus.addr1 = 32'h340; bus.wdata1 = 32'hA5;
    step(1);
    chk("rr1_addr", bus.BUS_addr, 32'h340);
    chk("rr1_mode", bus.BUS_mode, 1);
    step(1);
    bus.BUS_write_done = 1'b1;
    step(1);
    bus.BUS_write_done = 1'b0;
    chk("rr1_done", {bus.done0, bus.done1}, 2'b01);
    bus.req1 = 1'b0;
    step(1);
    chk("rr1_idle", bus.busy, 0);
    step(1);
    chk("rr2_addr", bus.BUS_addr, 32'h300);
    chk("rr2_start", bus.BUS_start_transaction, 1);
    step(1);
    bus.BUS_rdata = 32'hCAFE0001; bus.BUS_rdata_valid = 1'b1;
    step(1);
    bus.BUS_rdata_valid = 1'b0;
    chk("rr2_done", {bus.done0, bus.done1}, 2'b10);
    chk("rr2_rdata", bus.rdata, 32'hCAFE0001);
    bus.req0 = 1'b0;
    step(1);

    // timeout: read with no completion, abort after four WAIT cycles
    bus.req0 = 1'b1; bus.mode0 = 1'b0; bus.addr0 = 32'h400;
    step(1);
    chk("to_start", bus.BUS_start_transaction, 1);
    step(4);
    chk("to_early", {bus.done0, bus.busy}, 2'b01);
    step(1);
    chk("to_done", {bus.done0, bus.err0, bus.done1, bus.err1}, 4'b1100);
    chk("to_rdata_hold", bus.rdata, 32'hCAFE0001);
    bus.req0 = 1'b0;
    step(1);
    chk("to_err_pulse", bus.err0, 0);
    bus.req1 = 1'b1; bus.mode1 = 1'b1; bus.addr1 = 32'h500; bus.wdata1 = 32'h77;
    step(2);
    bus.BUS_write_done = 1'b1;
    step(1);
    bus.BUS_write_done = 1'b0;
    chk("to_next", {bus.done1, bus.err1}, 2'b10);
    bus.req1 = 1'b0;
    step(1);

    // port 0 served last so a tie would go to port 1 unless reset restores the pointer
    bus.req0 = 1'b1; bus.mode0 = 1'b0; bus.addr0 = 32'h600;
    step(2);
    snap = n_done;
    rst = 1'b1;
    #1;
    chk("ar_busy",  bus.busy, 0);
    chk("ar_start", bus.BUS_start_transaction, 0);
    bus.req0 = 1'b0;
    step(2);
    rst = 1'b0;
    chk("ar_nodone", n_done - snap, 0);
    bus.req0 = 1'b1; bus.mode0 = 1'b0; bus.addr0 = 32'h700;
    bus.req1 = 1'b1; bus.mode1 = 1'b1; bus.addr1 = 32'h740;
    step(1);
    chk("ar_tie_addr", bus.BUS_addr, 32'h700);
    chk("ar_tie_mode", bus.BUS_mode, 0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
